pipelined_select_adder: RTL and testbench
=========================================

# pipelined_select_adder

Parametrised, pipelined carry-select adder/subtractor for the ALU datapath. It is the successor of the fixed 32-bit combinational carry-select adder. It adds configurable width, block size and pipeline depth, a subtract mode, and a valid/ready handshake on both sides. Results carry the same Sum/Cout/Overflow semantics as the combinational adder, delayed by a fixed latency.

## Interface
Parameters:
- WIDTH, 32: operand and result width in bits; must be a multiple of BLOCK.
- BLOCK, 8: carry-select block width in bits.
- STAGES, 2: register stages, 1..WIDTH/BLOCK; (WIDTH/BLOCK) must be divisible by STAGES.

Ports:
- clk, input, 1: the single clock; all state changes on its rising edge.
- rst_n, input, 1: reset, synchronous, active-low.
- in_valid, input, 1: operand beat present.
- in_ready, output, 1: pipeline accepts a beat this cycle.
- A, input, WIDTH: operand A.
- B, input, WIDTH: operand B.
- Cin, input, 1: carry-in; ignored when Sub=1.
- Sub, input, 1: 1 = compute A − B.
- out_valid, output, 1: result beat present.
- out_ready, input, 1: consumer accepts the result.
- Sum, output, WIDTH: result.
- Cout, output, 1: carry out of the MSB.
- Overflow, output, 1: signed two's-complement overflow.

## Operation
- Operand B is transformed first: Beff = Sub ? ~B : B, and Ceff = Sub ? 1 : Cin. The datapath then computes A + Beff + Ceff.
- The operand is split into N = WIDTH/BLOCK blocks.
- Each block computes sum0/cout0, assuming carry-in 0, and sum1/cout1, assuming carry-in 1.
- The real incoming carry selects between them.
- Blocks are distributed evenly across stages, N/STAGES blocks per stage.
- The carry crossing a stage boundary is registered.
- Between stages, the pipeline carries:
  - the unprocessed upper operand slices;
  - the already-selected lower sum slices;
  - the running carry;
  - the valid bit;
  - the sign bits A[WIDTH-1] and Beff[WIDTH-1].
- Cout is the carry out of the top block.
- Overflow = (A_msb == Beff_msb) && (Sum_msb != A_msb).
- For subtraction, Cout=1 means no borrow (A ≥ B unsigned).
- All arithmetic is modulo 2^WIDTH; there is no width growth.

Handshake:
- Global advance enable: adv = !out_valid || out_ready.
- in_ready = adv.
- A beat is accepted when in_valid && in_ready.
- When adv=1, every stage register loads from its predecessor. Stage 0 loads the input beat with valid = in_valid.
- When adv=0, every stage holds, and Sum/Cout/Overflow/out_valid stay stable.
- Bubbles are not collapsed; beats leave in acceptance order.

## Timing
- Latency: a beat accepted at edge t appears with out_valid=1 after edge t+STAGES−1. With STAGES=1, the result is valid the cycle after acceptance.
- Throughput: 1 beat/cycle while out_ready=1.
- Reset (rst_n=0 at an edge):
  - All stage valid bits clear, so out_valid=0, Sum=0, Cout=0 and Overflow=0 from the next cycle.
  - in_ready=1 from the next cycle.
  - In-flight beats are discarded, including during mid-stall.
- Simultaneous output consumption and input acceptance in the same cycle is legal and required for full throughput.
- out_valid never drops without out_ready=1 at the preceding edge, except through reset.

## Configuration
- SEL_ADDER_SATURATE_EN defined: on signed overflow, Sum clamps to the most positive value (0x7FF…F) if A_msb=0, or the most negative value (0x800…0) if A_msb=1. Overflow and Cout are still reported unchanged. Clamping is applied at the last stage and adds no latency.
- SEL_ADDER_SATURATE_EN undefined: Sum wraps modulo 2^WIDTH. No clamp logic is generated.

## Structure
- Package sel_adder_pkg:
  - default WIDTH/BLOCK/STAGES constants;
  - a localparam function computing blocks-per-stage;
  - a typedef for the stage payload struct (valid, partial sum, carry, upper A/Beff slices, sign bits).
- Sub-module sel_adder_block, BLOCK bits wide:
  - combinational dual ripple adder;
  - outputs sum0, sum1, cout0, cout1;
  - instantiated N times through a generate loop.
- Stage registers and the handshake live in the top module.

## Test plan
Configuration: WIDTH=32, BLOCK=8, STAGES=2, out_ready=1 unless stated.
- A=7FFFFFFF, B=7FFFFFFF, Cin=0, Sub=0 → after 2 cycles: Sum=FFFFFFFE, Overflow=1, Cout=0. With SEL_ADDER_SATURATE_EN defined, Sum=7FFFFFFF.
- A=80000000, B=80000000, Cin=0 → Sum=00000000, Overflow=1, Cout=1. With SEL_ADDER_SATURATE_EN defined, Sum=80000000.
- A=12345678, B=87654321, Cin=1 → Sum=9999999A, Overflow=0, Cout=0.
- Sub=1, A=00000005, B=00000007 → Sum=FFFFFFFE, Overflow=0, Cout=0.
- Sub=1, A=80000000, B=00000001 → Sum=7FFFFFFF, Overflow=1, Cout=1.
- Stream 4 back-to-back beats and hold out_ready=0 for 3 cycles after the first result:
  - in_ready=0 and Sum stable throughout the stall;
  - no beat is lost or duplicated;
  - order is preserved.
  - Then assert rst_n=0 for one cycle mid-stream → out_valid=0 and Sum=0 the next cycle, and no stale beat emerges afterward.

Source files
------------

// File: rtl/sel_adder_pkg.sv
// Shared constants and types for the pipelined carry-select adder/subtractor.
package sel_adder_pkg;

    localparam int unsigned SA_WIDTH  = 32;
    localparam int unsigned SA_BLOCK  = 8;
    localparam int unsigned SA_STAGES = 2;

    function automatic int unsigned blocks_per_stage(
        input int unsigned width,
        input int unsigned block,
        input int unsigned stages
    );
        return (width / block) / stages;
    endfunction

    // Payload layout at the default width; the top redeclares it at its own WIDTH.
    typedef struct packed {
        logic                valid;
        logic [SA_WIDTH-1:0] sum;
        logic                carry;
        logic [SA_WIDTH-1:0] a;
        logic [SA_WIDTH-1:0] b;
        logic                a_msb;
        logic                b_msb;
    } sel_adder_stage_t;

endpackage

// File: rtl/pipelined_select_adder_block.sv
// One carry-select block: two ripple adders, one assuming carry-in 0, one carry-in 1.
module sel_adder_block
    import sel_adder_pkg::*;
#(
    parameter int unsigned BLOCK = SA_BLOCK
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    output logic [BLOCK-1:0] sum0,
    output logic [BLOCK-1:0] sum1,
    output logic             cout0,
    output logic             cout1
);

    logic c0;
    logic c1;

    always_comb begin
        c0   = 1'b0;
        c1   = 1'b1;
        sum0 = '0;
        sum1 = '0;
        for (int unsigned i = 0; i < BLOCK; i++) begin
            sum0[i] = a[i] ^ b[i] ^ c0;
            sum1[i] = a[i] ^ b[i] ^ c1;
            c0      = (a[i] & b[i]) | (c0 & (a[i] ^ b[i]));
            c1      = (a[i] & b[i]) | (c1 & (a[i] ^ b[i]));
        end
        cout0 = c0;
        cout1 = c1;
    end

endmodule

// File: rtl/pipelined_select_adder.sv
// Pipelined carry-select adder/subtractor with valid/ready on both sides.
// Optional feature: define SEL_ADDER_SATURATE_EN to clamp Sum on signed overflow.
module pipelined_select_adder
    import sel_adder_pkg::*;
#(
    parameter int unsigned WIDTH  = SA_WIDTH,
    parameter int unsigned BLOCK  = SA_BLOCK,
    parameter int unsigned STAGES = SA_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Overflow
);

    localparam int unsigned N   = WIDTH / BLOCK;
    localparam int unsigned BPS = blocks_per_stage(WIDTH, BLOCK, STAGES);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] sum;
        logic             carry;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             a_msb;
        logic             b_msb;
    } stage_t;

    stage_t           src  [STAGES];
    stage_t           nxt  [STAGES];
    stage_t           pipe [STAGES];

    logic [WIDTH-1:0] b_eff;
    logic             c_eff;
    logic             adv;

    logic [BLOCK-1:0] blk_sum0  [N];
    logic [BLOCK-1:0] blk_sum1  [N];
    logic             blk_cout0 [N];
    logic             blk_cout1 [N];

    logic             chain_c;
    int unsigned      idx;
    logic             ovf;

    assign adv      = !pipe[STAGES-1].valid || out_ready;
    assign in_ready = adv;

    // Stage s works on the payload feeding its register: the raw beat for stage 0.
    always_comb begin
        b_eff  = Sub ? ~B : B;
        c_eff  = Sub ? 1'b1 : Cin;
        src[0] = '{valid: in_valid, sum: '0, carry: c_eff, a: A, b: b_eff,
                   a_msb: A[WIDTH-1], b_msb: b_eff[WIDTH-1]};
        for (int unsigned s = 1; s < STAGES; s++) begin
            src[s] = pipe[s-1];
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_blk
        localparam int unsigned S = i / BPS;
        sel_adder_block #(.BLOCK(BLOCK)) u_blk (
            .a     (src[S].a[i*BLOCK +: BLOCK]),
            .b     (src[S].b[i*BLOCK +: BLOCK]),
            .sum0  (blk_sum0[i]),
            .sum1  (blk_sum1[i]),
            .cout0 (blk_cout0[i]),
            .cout1 (blk_cout1[i])
        );
    end

    // Carry select chain within each stage; the stage's carry-in comes from its register.
    always_comb begin
        chain_c = 1'b0;
        idx     = 0;
        for (int unsigned s = 0; s < STAGES; s++) begin
            nxt[s]  = src[s];
            chain_c = src[s].carry;
            for (int unsigned j = 0; j < BPS; j++) begin
                idx = s * BPS + j;
                nxt[s].sum[idx*BLOCK +: BLOCK] = chain_c ? blk_sum1[idx] : blk_sum0[idx];
                chain_c = chain_c ? blk_cout1[idx] : blk_cout0[idx];
            end
            nxt[s].carry = chain_c;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < STAGES; s++) begin
                pipe[s] <= '0;
            end
        end else if (adv) begin
            for (int unsigned s = 0; s < STAGES; s++) begin
                pipe[s] <= nxt[s];
            end
        end
    end

    assign out_valid = pipe[STAGES-1].valid;
    assign Cout      = pipe[STAGES-1].carry;
    assign ovf       = (pipe[STAGES-1].a_msb == pipe[STAGES-1].b_msb)
                    && (pipe[STAGES-1].sum[WIDTH-1] != pipe[STAGES-1].a_msb);
    assign Overflow  = ovf;

`ifdef SEL_ADDER_SATURATE_EN
    assign Sum = !ovf                 ? pipe[STAGES-1].sum
               : pipe[STAGES-1].a_msb ? {1'b1, {(WIDTH-1){1'b0}}}
               :                        {1'b0, {(WIDTH-1){1'b1}}};
`else
    assign Sum = pipe[STAGES-1].sum;
`endif

endmodule

// File: tb/tb_pipelined_select_adder.sv
// Scoreboard bench for pipelined_select_adder (WIDTH=32, BLOCK=8, STAGES=2).
module tb_pipelined_select_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        Cin;
    logic        Sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Sum;
    logic        Cout;
    logic        Overflow;

    always #5 clk = ~clk;

    pipelined_select_adder #(.WIDTH(32), .BLOCK(8), .STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .Sub       (Sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (Sum),
        .Cout      (Cout),
        .Overflow  (Overflow)
    );

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   beat   = 0;

`ifdef SEL_ADDER_SATURATE_EN
    localparam logic [31:0] E1 = 32'h7FFFFFFF;
    localparam logic [31:0] E2 = 32'h80000000;
    localparam logic [31:0] E5 = 32'h80000000;
`else
    localparam logic [31:0] E1 = 32'hFFFFFFFE;
    localparam logic [31:0] E2 = 32'h00000000;
    localparam logic [31:0] E5 = 32'h7FFFFFFF;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got Sum=%h expected no beat", Sum);
            end else begin
                mon_e = q.pop_front();
                check($sformatf("beat%0d_sum", beat), Sum, mon_e.sum);
                check($sformatf("beat%0d_cout", beat), {31'b0, Cout}, {31'b0, mon_e.cout});
                check($sformatf("beat%0d_ovf", beat), {31'b0, Overflow}, {31'b0, mon_e.ovf});
            end
            beat++;
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input logic sub, input logic [31:0] es, input logic ec, input logic eo);
        int n;
        A        = a;
        B        = b;
        Cin      = cin;
        Sub      = sub;
        in_valid = 1'b1;
        n        = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 within 50 cycles");
        end else begin
            q.push_back('{sum: es, cout: ec, ovf: eo});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("drain_queue_empty", q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected simulation end");
        $fatal(1);
    end

    initial begin
        int n;
        int seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        A         = '0;
        B         = '0;
        Cin       = 1'b0;
        Sub       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_sum", Sum, 32'h0);
        check("reset_cout", {31'b0, Cout}, 32'd0);
        check("reset_ovf", {31'b0, Overflow}, 32'd0);
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors, back to back.
        send(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b0, E1, 1'b0, 1'b1);
        send(32'h80000000, 32'h80000000, 1'b0, 1'b0, E2, 1'b1, 1'b1);
        send(32'h12345678, 32'h87654321, 1'b1, 1'b0, 32'h9999999A, 1'b0, 1'b0);
        send(32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
        send(32'h80000000, 32'h00000001, 1'b0, 1'b1, E5, 1'b1, 1'b1);
        drain();

        // Latency: not valid right after the accepting edge, valid after the next.
        send(32'h00000010, 32'h00000020, 1'b0, 1'b0, 32'h00000030, 1'b0, 1'b0);
        check("latency_edge_t", {31'b0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("latency_edge_t1", {31'b0, out_valid}, 32'd1);
        drain();

        // Stream 4 beats; stall 3 cycles after the first result is consumed.
        fork
            begin
                send(32'h00000001, 32'h00000002, 1'b0, 1'b0, 32'h00000003, 1'b0, 1'b0);
                send(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0);
                send(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
                send(32'h00010000, 32'h00000001, 1'b0, 1'b1, 32'h0000FFFF, 1'b1, 1'b0);
            end
            begin
                n = 0;
                @(negedge clk);
                while (!out_valid && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                check("stall_first_valid", {31'b0, out_valid}, 32'd1);
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_in_ready", {31'b0, in_ready}, 32'd0);
                    check("stall_out_valid", {31'b0, out_valid}, 32'd1);
                    check("stall_sum_stable", Sum, 32'h00000100);
                    @(posedge clk);
                end
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two beats held mid-stall.
        out_ready = 1'b0;
        send(32'h11111111, 32'h22222222, 1'b0, 1'b0, 32'h33333333, 1'b0, 1'b0);
        send(32'h00000001, 32'h00000001, 1'b0, 1'b0, 32'h00000002, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        check("midreset_out_valid", {31'b0, out_valid}, 32'd0);
        check("midreset_sum", Sum, 32'h0);
        check("midreset_in_ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b1;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("no_stale_beat", seen, 0);
        @(posedge clk);
        #1;
        send(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0);
        drain();
        check("total_beats", beat, 11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
